// File: rtl/sprite_cmd_sequencer.sv
// Sprite command sequencer: queues sprite updates and serialises each one into
// four command words, inserting a buffer-swap flush word on frame boundaries.
module sprite_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [5:0]  upd_component,
  input  logic [4:0]  upd_child,
  input  logic        upd_visible,
  input  logic        upd_flip,
  input  logic [4:0]  upd_pattern,
  input  logic [9:0]  upd_x,
  input  logic [9:0]  upd_y,
  input  logic [9:0]  upd_shift,
  input  logic        frame_tick,
  output logic [31:0] writedata,
  output logic        cur_buf,
  output logic        busy,
  output logic [7:0]  dropped_frames
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = 48;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PAT   = 3'd1,
    XPOS  = 3'd2,
    YPOS  = 3'd3,
    SHIFT = 3'd4,
    FLUSH = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] cur;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               flush_pending;
  logic               push;
  logic               pop;
  logic               enter_flush;
  logic [31:0]        word_c;

  // Fields of the update currently being serialised
  logic [5:0]  cur_component;
  logic [4:0]  cur_child;
  logic        cur_visible;
  logic        cur_flip;
  logic [4:0]  cur_pattern;
  logic [9:0]  cur_x;
  logic [9:0]  cur_y;
  logic [9:0]  cur_shift;
  logic [14:0] upd_hdr;
  logic [3:0]  upd_flags;

  assign entry_in = {upd_component, upd_child, upd_visible, upd_flip,
                     upd_pattern, upd_x, upd_y, upd_shift};
  assign {cur_component, cur_child, cur_visible, cur_flip,
          cur_pattern, cur_x, cur_y, cur_shift} = cur;
  assign upd_hdr   = {cur_component, cur_child, 4'h1};
  assign upd_flags = {1'b0, cur_visible, cur_flip, 1'b0};

  assign upd_ready   = (count < CNT_W'(FIFO_DEPTH));
  assign busy        = (state != IDLE) || (count != '0);
  assign push        = upd_valid && upd_ready;
  assign pop         = (state_next == PAT);
  assign enter_flush = (state_next == FLUSH);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: IDLE, SHIFT and FLUSH share one dispatch rule so updates chain without gaps
  always_comb begin
    state_next = state;
    case (state)
      IDLE, SHIFT, FLUSH: begin
        if (flush_pending)      state_next = FLUSH;
        else if (count != '0)   state_next = PAT;
        else                    state_next = IDLE;
      end
      PAT:     state_next = XPOS;
      XPOS:    state_next = YPOS;
      YPOS:    state_next = SHIFT;
      default: state_next = IDLE;
    endcase
  end

  // Word to be registered onto writedata at the end of the current state
  always_comb begin
    word_c = '0;
    case (state)
      PAT:     word_c = {upd_hdr, 3'b001, upd_flags, 5'd0, cur_pattern};
      XPOS:    word_c = {upd_hdr, 3'b010, upd_flags, cur_x};
      YPOS:    word_c = {upd_hdr, 3'b011, upd_flags, cur_y};
      SHIFT:   word_c = {upd_hdr, 3'b100, upd_flags, cur_shift};
      FLUSH:   word_c = {6'd0, 5'd0, 4'hF, 3'd0, ~cur_buf, 13'd0};
      default: word_c = '0;
    endcase
  end

  // FIFO pointers, flush bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cur            <= '0;
      flush_pending  <= 1'b0;
      dropped_frames <= 8'd0;
      writedata      <= 32'd0;
      cur_buf        <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        cur    <= mem[rd_ptr];
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // A tick coinciding with FLUSH entry re-arms the flag rather than being dropped
      flush_pending <= frame_tick | (flush_pending & ~enter_flush);
      if (frame_tick && flush_pending && !enter_flush && (dropped_frames != 8'hFF))
        dropped_frames <= dropped_frames + 8'd1;
      writedata <= word_c;
      if (state == FLUSH) cur_buf <= ~cur_buf;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

endmodule

// File: tb/tb_sprite_cmd_sequencer.sv
// Randomised self-checking bench for sprite_cmd_sequencer against a
// word-stream reference model.
module tb_sprite_cmd_sequencer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [5:0]  upd_component;
  logic [4:0]  upd_child;
  logic        upd_visible;
  logic        upd_flip;
  logic [4:0]  upd_pattern;
  logic [9:0]  upd_x;
  logic [9:0]  upd_y;
  logic [9:0]  upd_shift;
  logic        frame_tick;
  logic [31:0] writedata;
  logic        cur_buf;
  logic        busy;
  logic [7:0]  dropped_frames;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending updates, words still owed by the current operation
  logic [47:0] m_upd[$];
  logic [31:0] m_words[$];
  logic        m_pend;
  int          m_drops;
  logic        m_buf;
  logic [31:0] m_wd;

  sprite_cmd_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_component(upd_component), .upd_child(upd_child),
    .upd_visible(upd_visible), .upd_flip(upd_flip), .upd_pattern(upd_pattern),
    .upd_x(upd_x), .upd_y(upd_y), .upd_shift(upd_shift),
    .frame_tick(frame_tick), .writedata(writedata), .cur_buf(cur_buf),
    .busy(busy), .dropped_frames(dropped_frames)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] mk(input int comp, input int child, input int vis,
                                     input int flip, input int pat, input int x,
                                     input int y, input int sh);
    return {6'(comp), 5'(child), 1'(vis), 1'(flip), 5'(pat), 10'(x), 10'(y), 10'(sh)};
  endfunction

  function automatic logic [31:0] upd_word(input logic [47:0] e, input int dt, input int val);
    longint w;
    logic [31:0] r;
    w = (longint'(e[47:42]) * 64'd67108864) + (longint'(e[41:37]) * 64'd2097152)
        + 64'd131072 + (longint'(dt) * 64'd16384)
        + (longint'(e[36]) * 64'd4096) + (longint'(e[35]) * 64'd2048) + longint'(val);
    r = w[31:0];
    return r;
  endfunction

  function automatic logic [31:0] flush_word(input logic b);
    return 32'h001E0000 | (b ? 32'h00002000 : 32'h0);
  endfunction

  // Advance the model across one rising edge using the inputs now being driven
  task automatic model_step();
    logic        ready;
    logic        fl;
    logic [47:0] e;
    if (reset) begin
      m_upd.delete(); m_words.delete();
      m_pend = 1'b0; m_drops = 0; m_buf = 1'b0; m_wd = 32'h0;
      return;
    end
    ready = (m_upd.size() < DEPTH);
    m_wd  = (m_words.size() != 0) ? m_words.pop_front() : 32'h0;
    if (m_wd[20:17] == 4'hF) m_buf = ~m_buf;
    fl = 1'b0;
    if (m_words.size() == 0) begin
      if (m_pend) begin
        m_words.push_back(flush_word(~m_buf));
        fl = 1'b1;
      end else if (m_upd.size() != 0) begin
        e = m_upd.pop_front();
        m_words.push_back(upd_word(e, 1, int'(e[34:30])));
        m_words.push_back(upd_word(e, 2, int'(e[29:20])));
        m_words.push_back(upd_word(e, 3, int'(e[19:10])));
        m_words.push_back(upd_word(e, 4, int'(e[9:0])));
      end
    end
    if (upd_valid && ready)
      m_upd.push_back({upd_component, upd_child, upd_visible, upd_flip,
                       upd_pattern, upd_x, upd_y, upd_shift});
    if (frame_tick && m_pend && !fl && m_drops < 255) m_drops++;
    m_pend = frame_tick ? 1'b1 : (fl ? 1'b0 : m_pend);
  endtask

  task automatic cycle(input logic rst_i, input logic tick_i, input logic v_i, input logic [47:0] e_i);
    reset      = rst_i;
    frame_tick = tick_i;
    upd_valid  = v_i;
    {upd_component, upd_child, upd_visible, upd_flip,
     upd_pattern, upd_x, upd_y, upd_shift} = e_i;
    model_step();
    @(negedge clk);
    check_eq("writedata", writedata, m_wd);
    check_eq("cur_buf", 32'(cur_buf), 32'(m_buf));
    check_eq("upd_ready", 32'(upd_ready), 32'((m_upd.size() < DEPTH) ? 1 : 0));
    check_eq("busy", 32'(busy), 32'(((m_words.size() != 0) || (m_upd.size() != 0)) ? 1 : 0));
    check_eq("dropped_frames", 32'(dropped_frames), 32'(m_drops));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 48'h0);
  endtask

  initial begin
    logic [47:0] a;
    logic [47:0] r;

    cycle(1'b1, 1'b0, 1'b0, 48'h0);
    cycle(1'b1, 1'b0, 1'b0, 48'h0);
    check_eq("rst_wd", writedata, 32'h0);
    check_eq("rst_ready", 32'(upd_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Single update, first word two cycles after the push
    a = mk(14, 0, 1, 0, 0, 100, 50, 0);
    cycle(1'b0, 1'b0, 1'b1, a);
    idle(2);
    check_eq("single_pat", writedata, 32'h38025000);
    idle(1);
    check_eq("single_x", writedata, 32'h38029064);
    idle(1);
    check_eq("single_y", writedata, 32'h3802D032);
    idle(1);
    check_eq("single_shift", writedata, 32'h38031000);
    idle(1);
    check_eq("single_after", writedata, 32'h0);

    // Idle frame ticks toggle the active buffer
    cycle(1'b0, 1'b1, 1'b0, 48'h0);
    idle(2);
    check_eq("flush0_word", writedata, 32'h001E2000);
    idle(1);
    check_eq("flush0_buf", 32'(cur_buf), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 48'h0);
    idle(2);
    check_eq("flush1_word", writedata, 32'h001E0000);
    idle(1);
    check_eq("flush1_buf", 32'(cur_buf), 32'd0);

    // Three ticks while an update is in flight coalesce into one flush
    cycle(1'b0, 1'b0, 1'b1, mk(3, 7, 0, 1, 21, 900, 17, 1023));
    cycle(1'b0, 1'b1, 1'b0, 48'h0);
    cycle(1'b0, 1'b1, 1'b0, 48'h0);
    cycle(1'b0, 1'b1, 1'b0, 48'h0);
    idle(6);
    check_eq("coalesce_drops", 32'(dropped_frames), 32'd2);

    // Tick during YPOS with a second update queued
    cycle(1'b0, 1'b0, 1'b1, mk(1, 2, 1, 1, 5, 10, 20, 30));
    cycle(1'b0, 1'b0, 1'b1, mk(2, 3, 0, 0, 6, 11, 21, 31));
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 48'h0);
    idle(10);

    // FIFO fills while a sequence holds the FSM
    cycle(1'b0, 1'b0, 1'b1, mk(10, 1, 1, 0, 1, 1, 1, 1));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, mk(11 + i, i, 0, 1, i, i, i, i));
    check_eq("full_ready", 32'(upd_ready), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, mk(20, 9, 1, 1, 9, 9, 9, 9));
    cycle(1'b0, 1'b0, 1'b1, mk(20, 9, 1, 1, 9, 9, 9, 9));
    idle(24);

    // Reset in the XPOS cycle aborts the sequence
    cycle(1'b0, 1'b0, 1'b1, mk(30, 4, 1, 0, 3, 300, 200, 100));
    idle(2);
    cycle(1'b1, 1'b0, 1'b0, 48'h0);
    check_eq("abort_wd", writedata, 32'h0);
    check_eq("abort_ready", 32'(upd_ready), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_buf", 32'(cur_buf), 32'd0);
    idle(5);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom(), $urandom()};
      cycle(($urandom_range(199) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(9) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(1) == 0) ? 1'b1 : 1'b0, r);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_cmd_sequencer.md
SPRITE_CMD_SEQUENCER -- requirements
Module: sprite_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of sprite updates that can be queued.
REQ-002 Port clk, input, 1: sole clock.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port upd_valid, input, 1: a sprite update is offered.
REQ-005 Port upd_ready, output, 1: the block can accept an update this cycle.
REQ-006 Port upd_component, input, 6: target component ID.
REQ-007 Port upd_child, input, 5: child index.
REQ-008 Port upd_visible / upd_flip, input, 1 each: visibility and flip bits.
REQ-009 Port upd_pattern, input, 5: pattern index.
REQ-010 Port upd_x / upd_y / upd_shift, input, 10 each: x, y and shift values.
REQ-011 Port frame_tick, input, 1: single-cycle frame boundary pulse.
REQ-012 Port writedata, output, 32: command word to the display components.
REQ-013 Port cur_buf, output, 1: buffer currently targeted by updates.
REQ-014 Port busy, output, 1: FIFO is non-empty or a word is being emitted.
REQ-015 Port dropped_frames, output, 8: saturating count of frame_ticks coalesced into an already pending flush.

Function
REQ-016 Word format SHALL be fixed:
- [31:26] component
- [25:21] child
- [20:17] info
- [16:14] data_type
- [13] buffer_to_activate
- [12:0] message_data
REQ-017 Idle word SHALL be 32'h0 (info = 0, a no-op); writedata SHALL be registered and SHALL hold a command for exactly one cycle, then return to 0 unless the next command follows.
REQ-018 Update words SHALL carry: info = 4'h1, bit13 = 0, message_data[12] = visible, [11] = flip, [10] = 0.
REQ-019 Each accepted update SHALL emit 4 words on consecutive cycles, in this order:
- data_type 3'b001, [9:0] = zero-extended pattern
- 3'b010, x
- 3'b011, y
- 3'b100, shift
REQ-020 Flush word SHALL be component = 0, child = 0, info = 4'hF, data_type = 0, bit13 = ~cur_buf, message_data = 0; cur_buf SHALL toggle on the cycle after the flush word is driven.
REQ-021 FSM states SHALL be IDLE, PAT, XPOS, YPOS, SHIFT, FLUSH.
REQ-022 FSM transitions from IDLE: flush pending -> FLUSH; else FIFO non-empty -> PAT (pop); else stay in IDLE.
REQ-023 FSM transitions PAT -> XPOS -> YPOS -> SHIFT are unconditional.
REQ-024 FSM transitions from SHIFT and from FLUSH SHALL use the same rule as from IDLE, so back-to-back updates have no gap cycle.
REQ-025 Each state SHALL drive its word on writedata in the following cycle (1-cycle latency from state to output).
REQ-026 Flush SHALL take priority over queued updates but SHALL never interrupt a 4-word update sequence.
REQ-027 frame_tick SHALL set flush_pending; flush_pending SHALL clear when FLUSH is entered.
REQ-028 frame_tick arriving while flush_pending is already 1 SHALL NOT queue a second flush and SHALL increment dropped_frames, saturating at 8'hFF.
REQ-029 frame_tick in the same cycle FLUSH is entered SHALL leave flush_pending = 1 (the new tick is not lost).
REQ-030 upd_ready SHALL equal (FIFO count < FIFO_DEPTH); a push occurs when upd_valid && upd_ready.
REQ-031 A simultaneous push and pop when the FIFO is full SHALL NOT be accepted, since upd_ready is derived from the pre-pop count.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be $clog2(FIFO_DEPTH) + 1.
REQ-033 An update pushed into an empty FIFO in IDLE SHALL enter PAT on the next cycle; its first word appears 2 cycles after the push.
REQ-034 busy SHALL be 1 when FSM != IDLE or FIFO count != 0.

Reset
REQ-035 On reset: writedata = 0, cur_buf = 0, FSM = IDLE, FIFO emptied, flush_pending = 0, dropped_frames = 0, upd_ready = 1, busy = 0.
REQ-036 Reset asserted mid-sequence SHALL abort the sequence; writedata SHALL be 0 in the cycle after reset is sampled, and no partial remainder SHALL be emitted afterwards.

Verification
REQ-037 Single update (component 6'h0E, child 0, visible 1, flip 0, pattern 0, x 100, y 50, shift 0) -> words 32'h38025000, then x = 100 / y = 50 words, then shift = 0 word on 4 consecutive cycles; writedata = 0 afterwards.
REQ-038 frame_tick while idle with cur_buf = 0 -> one word 32'h001E2000, then cur_buf = 1; a second tick -> bit13 = 0, then cur_buf = 0.
REQ-039 frame_tick during the YPOS word of an update with a second update queued -> SHIFT word, then FLUSH word, then the second update's PAT word, with no gaps.
REQ-040 Push 5 updates while the FSM is held in a sequence, FIFO_DEPTH = 4 -> upd_ready = 0 after the 4th accept; the 5th update is accepted only after the first pop.
REQ-041 Three frame_ticks before the FSM can flush -> one flush word emitted, dropped_frames = 2.
REQ-042 Reset asserted on the XPOS cycle -> writedata = 0 the next cycle, no YPOS/SHIFT words appear afterwards, and all REQ-035 values hold.
